// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared FSM states, NOP word and byte-lane mapping for the byte-loaded instruction memory.
package instr_mem_pkg;
    typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_e;

    localparam int unsigned NOP = 0;

    function automatic int unsigned byte_lane(input int unsigned cnt, input int unsigned nb, input bit le);
        return le ? cnt : nb - 1 - cnt;
    endfunction
endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: takes one byte per rising edge of write_Ready and packs bytes into DATA_W-bit words,
// emitting a zero-padded partial word on flush.
module byte_word_assembler import instr_mem_pkg::*; #(
    parameter int DATA_W        = 32,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              full,
    input  logic              write,
    input  logic              write_Ready,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_valid,
    output logic              partial,
    output logic              drop
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int CNT_W = NB > 1 ? $clog2(NB) : 1;

    logic              wr_prev_q;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d, filled;
    logic              strobe, take, last;
    int unsigned       lane;

    always_comb begin
        lane = byte_lane(32'(byte_cnt_q), NB, LITTLE_ENDIAN != 0);
        strobe = write && write_Ready && !wr_prev_q;
        take = load && strobe && !full;
        drop = load && strobe && full;
        last = byte_cnt_q == CNT_W'(NB - 1);
        filled = sr_q;
        filled[lane*8 +: 8] = byte_in;
        partial = byte_cnt_q != '0;
        word = take ? filled : sr_q;
        word_valid = (take && last) || (flush && partial && !full);
        // Outside LOAD the lanes are kept clear so each session and each flush starts from zero.
        byte_cnt_d = !load ? '0 : take ? (last ? '0 : byte_cnt_q + CNT_W'(1)) : byte_cnt_q;
        sr_d = !load ? '0 : take ? (last ? '0 : filled) : sr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_prev_q  <= 1'b0;
            byte_cnt_q <= '0;
            sr_q       <= '0;
        end else begin
            wr_prev_q  <= write_Ready;
            byte_cnt_q <= byte_cnt_d;
            sr_q       <= sr_d;
        end
    end
endmodule

// File: rtl/instr_mem_byte_loader.sv
// instr_mem_byte_loader: instruction memory loaded serially byte by byte, with a registered fetch port
// and RUN/LOAD/FLUSH arbitration between loading and fetching.
module instr_mem_byte_loader import instr_mem_pkg::*; #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] instruction,
    output logic              valid,
    output logic              addr_err,
    input  logic              write,
    input  logic [7:0]        write_Instruction,
    input  logic              write_Ready,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                overflow_q, overflow_d, load_done_q, load_done_d;
    logic [DATA_W-1:0]   instruction_q, instruction_d;
    logic                valid_q, valid_d, addr_err_q, addr_err_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   word;
    logic                word_valid, partial, drop, full, run, start, err;
    logic [ADDR_W-1:0]   idx;

    byte_word_assembler #(.DATA_W(DATA_W), .LITTLE_ENDIAN(LITTLE_ENDIAN)) u_asm (
        .clk(clk), .rst(rst),
        .load(state_q == LOAD), .flush(state_q == FLUSH), .full(full),
        .write(write), .write_Ready(write_Ready), .byte_in(write_Instruction),
        .word(word), .word_valid(word_valid), .partial(partial), .drop(drop)
    );

    always_comb begin
        full = word_count_q == FULL;
        run = state_q == RUN;
        start = run && write;
        state_d = run ? (write ? LOAD : RUN) : state_q == LOAD ? (write ? LOAD : FLUSH) : RUN;
        load_done_d = state_q == LOAD && !write;
        word_count_d = start ? '0 : word_valid ? word_count_q + 1'b1 : word_count_q;
        overflow_d = start ? 1'b0 : (drop || (state_q == FLUSH && partial && full)) ? 1'b1 : overflow_q;
        idx = addr[ADDR_W+1:2];
        err = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
        // While loading the pipeline only ever sees NOPs, never an address error.
        valid_d = rd_en;
        addr_err_d = rd_en ? run && err : addr_err_q;
        instruction_d = !rd_en ? instruction_q :
                        (!run || err || {1'b0, idx} >= word_count_q) ? DATA_W'(NOP) : mem[idx];
    end

    always_ff @(posedge clk) begin
        if (word_valid)
            mem[word_count_q[ADDR_W-1:0]] <= word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            word_count_q  <= '0;
            overflow_q    <= 1'b0;
            load_done_q   <= 1'b0;
            instruction_q <= '0;
            valid_q       <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_count_q  <= word_count_d;
            overflow_q    <= overflow_d;
            load_done_q   <= load_done_d;
            instruction_q <= instruction_d;
            valid_q       <= valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign instruction = instruction_q;
    assign valid       = valid_q;
    assign addr_err    = addr_err_q;
    assign load_done   = load_done_q;
    assign word_count  = word_count_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_instr_mem_byte_loader.sv
// tb_instr_mem_byte_loader: little- and big-endian 4-word instances driven in lockstep and checked
// against a byte-queue reference model, constant fetch vectors and hand-written corner sequences.
module tb_instr_mem_byte_loader;
    localparam int AW = 2;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]   addr = '0;
    logic          rd_en = 1'b0, write = 1'b0, write_Ready = 1'b0;
    logic [7:0]    write_Instruction = '0;
    logic [DW-1:0] ins_le, ins_be;
    logic          v_le, v_be, e_le, e_be, ld_le, ld_be, ov_le, ov_be;
    logic [AW:0]   wc_le, wc_be;

    instr_mem_byte_loader #(.ADDR_W(AW), .DATA_W(DW), .LITTLE_ENDIAN(1)) u_le (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .instruction(ins_le), .valid(v_le),
        .addr_err(e_le), .write(write), .write_Instruction(write_Instruction), .write_Ready(write_Ready),
        .load_done(ld_le), .word_count(wc_le), .overflow(ov_le));

    instr_mem_byte_loader #(.ADDR_W(AW), .DATA_W(DW), .LITTLE_ENDIAN(0)) u_be (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .instruction(ins_be), .valid(v_be),
        .addr_err(e_be), .write(write), .write_Instruction(write_Instruction), .write_Ready(write_Ready),
        .load_done(ld_be), .word_count(wc_be), .overflow(ov_be));

    typedef struct {
        logic [31:0] a;
        logic [31:0] le;
        logic [31:0] be;
        logic        err;
    } vec_t;
    vec_t vecs[7];

    int tests = 0;
    int fails = 0;

    // Reference model: the bytes of one session, and the words they imply.
    logic [7:0]  q[$];
    logic [31:0] mem_le[4], mem_be[4];
    int          wc_m = 0;
    bit          ov_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_word(input int k, input bit le);
        logic [31:0] w;
        logic [7:0]  b;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            b = (4 * k + j < q.size()) ? q[4 * k + j] : 8'h00;
            w = w | (32'(b) << (le ? 8 * j : 8 * (3 - j)));
        end
        return w;
    endfunction

    function automatic logic [31:0] exp_ins(input logic [31:0] a, input bit le);
        bit err;
        int idx;
        err = (a[1:0] != 2'b00) || (a[31:4] != 28'h0);
        idx = int'(a[3:2]);
        if (err || idx >= wc_m) return 32'h0;
        return le ? mem_le[idx] : mem_be[idx];
    endfunction

    task automatic model_close();
        int words;
        words = (q.size() + 3) / 4;
        wc_m = words > 4 ? 4 : words;
        ov_m = q.size() > 16;
        for (int k = 0; k < wc_m; k++) begin
            mem_le[k] = pack_word(k, 1'b1);
            mem_be[k] = pack_word(k, 1'b0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_session();
        write = 1'b1;
        q.delete();
        tick();
    endtask

    task automatic strobe(input logic [7:0] b, input int hi);
        write_Instruction = b;
        write_Ready = 1'b1;
        repeat (hi) tick();
        write_Ready = 1'b0;
        tick();
        q.push_back(b);
    endtask

    task automatic end_session(input bit late_strobe);
        write = 1'b0;
        if (late_strobe) begin
            write_Ready = 1'b1;
            write_Instruction = 8'hEE;
        end
        tick();
        write_Ready = 1'b0;
        chk("load_done_le pulse", 64'(ld_le), 64'd1);
        chk("load_done_be pulse", 64'(ld_be), 64'd1);
        tick();
        model_close();
        chk("load_done_le end", 64'(ld_le), 64'd0);
        chk("word_count_le", 64'(wc_le), 64'(wc_m));
        chk("word_count_be", 64'(wc_be), 64'(wc_m));
        chk("overflow_le", 64'(ov_le), 64'(ov_m));
        chk("overflow_be", 64'(ov_be), 64'(ov_m));
    endtask

    task automatic fetch(input logic [31:0] a);
        logic [31:0] xl, xb;
        bit err;
        xl = exp_ins(a, 1'b1);
        xb = exp_ins(a, 1'b0);
        err = (a[1:0] != 2'b00) || (a[31:4] != 28'h0);
        addr = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fetch valid_le", 64'(v_le), 64'd1);
        chk("fetch valid_be", 64'(v_be), 64'd1);
        chk("fetch ins_le", 64'(ins_le), 64'(xl));
        chk("fetch ins_be", 64'(ins_be), 64'(xb));
        chk("fetch addr_err_le", 64'(e_le), 64'(err));
        chk("fetch addr_err_be", 64'(e_be), 64'(err));
        addr = $urandom;
        tick();
        chk("idle valid_le", 64'(v_le), 64'd0);
        chk("idle ins_le hold", 64'(ins_le), 64'(xl));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ins_le"}, 64'(ins_le), 64'd0);
        chk({tag, " ins_be"}, 64'(ins_be), 64'd0);
        chk({tag, " valid"}, 64'({v_le, v_be}), 64'd0);
        chk({tag, " addr_err"}, 64'({e_le, e_be}), 64'd0);
        chk({tag, " load_done"}, 64'({ld_le, ld_be}), 64'd0);
        chk({tag, " word_count"}, 64'({wc_le, wc_be}), 64'd0);
        chk({tag, " overflow"}, 64'({ov_le, ov_be}), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        int nb;
        vecs[0] = '{32'h0000_0000, 32'h1300_35D3, 32'hD335_0013, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h4433_2211, 32'h1122_3344, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h0, 32'h0, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'h0, 32'h0, 1'b0};
        vecs[4] = '{32'h0000_0002, 32'h0, 32'h0, 1'b1};
        vecs[5] = '{32'h0000_0010, 32'h0, 32'h0, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h0, 32'h0, 1'b1};

        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // Two words, with a fetch issued while in LOAD.
        start_session();
        addr = 32'h2;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("load fetch valid", 64'(v_le), 64'd1);
        chk("load fetch ins", 64'({ins_le, ins_be}), 64'd0);
        chk("load fetch err", 64'({e_le, e_be}), 64'd0);
        foreach (vecs[i]) if (i < 2) begin
            strobe(vecs[i].le[7:0], 1);
            strobe(vecs[i].le[15:8], 1);
            strobe(vecs[i].le[23:16], 1);
            strobe(vecs[i].le[31:24], 1);
        end
        end_session(1'b0);
        chk("two words count", 64'(wc_le), 64'd2);
        for (int i = 0; i < 7; i++) begin
            addr = vecs[i].a;
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            chk("vec valid", 64'({v_le, v_be}), 64'h3);
            chk("vec ins_le", 64'(ins_le), 64'(vecs[i].le));
            chk("vec ins_be", 64'(ins_be), 64'(vecs[i].be));
            chk("vec addr_err", 64'({e_le, e_be}), 64'({vecs[i].err, vecs[i].err}));
        end

        // A strobe held high for 10 cycles counts once; the flush pads the partial word.
        start_session();
        strobe(8'hD3, 10);
        end_session(1'b0);
        fetch(32'h0);
        chk("long strobe ins_le", 64'(ins_le), 64'h0000_00D3);
        chk("long strobe ins_be", 64'(ins_be), 64'hD300_0000);
        fetch(32'h4);

        // 17 words into a 4-word array.
        start_session();
        for (int i = 0; i < 68; i++) strobe(8'(i + 1), 1);
        end_session(1'b0);
        chk("overflow count", 64'(wc_le), 64'd4);
        chk("overflow flag", 64'(ov_le), 64'd1);
        for (int i = 0; i < 5; i++) fetch(32'(4 * i));
        fetch(32'hC);
        chk("overflow word3", 64'(ins_le), 64'h100F_0E0D);

        // write re-raised during FLUSH: the strobe seen in the following RUN cycle is lost.
        start_session();
        strobe(8'hA1, 1);
        write = 1'b0;
        tick();
        chk("reflush load_done", 64'(ld_le), 64'd1);
        write = 1'b1;
        tick();
        model_close();
        chk("reflush count", 64'(wc_le), 64'(wc_m));
        q.delete();
        write_Instruction = 8'h5A;
        write_Ready = 1'b1;
        tick();
        write_Ready = 1'b0;
        tick();
        strobe(8'h3C, 1);
        end_session(1'b0);
        fetch(32'h0);
        chk("reflush ins_le", 64'(ins_le), 64'h0000_003C);

        // Reset in the middle of byte 3 of word 2.
        start_session();
        for (int i = 0; i < 6; i++) strobe(8'(8'h40 + i), 1);
        write_Instruction = 8'h77;
        write_Ready = 1'b1;
        #2 rst = 1'b0;
        #1 chk_all_zero("async reset");
        write = 1'b0;
        write_Ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        q.delete();
        wc_m = 0;
        ov_m = 0;
        fetch(32'h0);
        chk("post reset ins", 64'(ins_le), 64'd0);
        start_session();
        for (int i = 0; i < 4; i++) strobe(8'(8'h90 + i), 1);
        end_session(1'b0);
        fetch(32'h0);
        chk("reload ins_le", 64'(ins_le), 64'h9392_9190);

        // Randomised sessions against the byte-queue model.
        for (int s = 0; s < 30; s++) begin
            start_session();
            nb = $urandom_range(0, 20);
            for (int i = 0; i < nb; i++) strobe(8'($urandom), $urandom_range(1, 3));
            end_session(1'($urandom_range(0, 1)));
            for (int f = 0; f < 4; f++) begin
                case ($urandom_range(0, 3))
                    0: a = {28'h0, 2'($urandom), 2'b00};
                    1: a = {28'h0, 2'($urandom), 2'($urandom_range(1, 3))};
                    2: a = {28'($urandom_range(1, 32'h0FFF_FFFF)), 4'($urandom)};
                    default: a = $urandom;
                endcase
                fetch(a);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_mem_byte_loader.md
Name: instr_mem_byte_loader

Overview:
Parametrised successor to the processor's instruction memory. It serially loads instructions one byte at a time from an external loader (host or UART bridge), assembles the bytes into DATA_W-bit words and writes them into a word-addressed array. It serves registered instruction fetches to the pipeline's IF stage. It adds the following, none of which the previous block had:
- configurable width, depth and byte order
- edge-detected byte strobe
- partial-word flush
- overflow and address error flags
- load/run arbitration

Parameters:
ADDR_W, 8, word-index bits; DEPTH = 2**ADDR_W words
DATA_W, 32, instruction width; must be a multiple of 8
LITTLE_ENDIAN, 1, 1 = first received byte goes to bits [7:0]; 0 = first byte goes to [DATA_W-1:DATA_W-8]

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
addr  in  32  byte address from the PC; word index = addr[ADDR_W+1:2]
rd_en  in  1  fetch request
instruction  out  DATA_W  fetched word, registered
valid  out  1  instruction holds the result of the previous cycle's rd_en
addr_err  out  1  previous fetch was misaligned or out of range
write  in  1  load mode; level signal
write_Instruction  in  8  load byte
write_Ready  in  1  byte strobe; a byte is taken on its rising edge
load_done  out  1  pulses 1 cycle when a load session closes
word_count  out  ADDR_W+1  number of words committed by the last or current load
overflow  out  1  sticky: bytes were dropped because the array was full

Behaviour:
Reset values (rst=0, async):
- instruction=0, valid=0, addr_err=0, load_done=0, word_count=0, overflow=0
- FSM=RUN, byte counter=0, shift register=0, write_Ready history register=0
- The memory array is not reset.

Strobe detection:
- wr_prev registers write_Ready.
- A byte is accepted when write=1 && write_Ready=1 && wr_prev=0: one byte per rising edge, regardless of pulse length.

FSM states: RUN, LOAD, FLUSH.
- RUN -> LOAD when write=1. On entry: word_count=0, byte counter=0, overflow=0.
- LOAD:
  - Each accepted byte is placed at lane byte_cnt (lane order per LITTLE_ENDIAN), then byte_cnt increments.
  - When the last lane (DATA_W/8-1) is filled, the assembled word is written to mem[word_count] in the same edge, word_count increments and byte_cnt returns to 0.
  - If word_count==DEPTH, the byte is dropped and overflow is set.
- LOAD -> FLUSH when write=0.
- FLUSH (1 cycle):
  - If byte_cnt!=0, the partial word is committed with unfilled lanes set to 0 and word_count increments (unless full, in which case overflow is set).
  - load_done=1 for this cycle only, then -> RUN.
- Strobe on the exact cycle write drops: the byte is ignored.
- write re-asserted during FLUSH: ignored until RUN, so the next session starts 1 cycle later.

Fetch (1-cycle latency):
- rd_en at edge N -> instruction/valid at edge N+1.
- In RUN:
  - idx = addr[ADDR_W+1:2]
  - addr_err = (addr[1:0]!=0) || (addr[31:ADDR_W+2]!=0)
  - instruction = 0 if addr_err or idx>=word_count (unloaded words read as NOP 0); otherwise mem[idx]
- In LOAD/FLUSH: rd_en gives valid=1, instruction=0, addr_err=0 (the pipeline sees NOPs while loading).
- rd_en=0: valid=0 next cycle and instruction holds its value.

Reset mid-load: the session is abandoned and word_count=0, so previously written words read as 0 until reloaded.

Decomposition:
- Shared package instr_mem_pkg holds:
  - FSM state enum (RUN, LOAD, FLUSH)
  - NOP constant (all zeros)
  - function to compute a byte lane from byte_cnt and LITTLE_ENDIAN
- One sub-module, byte_word_assembler, contains:
  - strobe edge detect, byte_cnt, shift register and pad-flush
  - outputs word, word_valid, partial
- The top module holds the FSM, memory array and fetch port.

Test Plan:
1. Reset, write=1, strobes with bytes D3,35,00,13, write=0 (LE) -> load_done pulse, word_count=1; fetch addr=0 -> instruction=0x13_00_35_D3 one cycle after rd_en.
2. LITTLE_ENDIAN=0, same bytes -> instruction=0xD3350013.
3. write_Ready held high for 10 cycles with 1 byte D3, then write=0 -> single byte accepted; flush gives mem[0]=0x000000D3, word_count=1.
4. ADDR_W=2, load 17 full words -> word_count=4, overflow=1, mem[0..3] hold the first 4 words; fetch addr=0x10 -> addr_err=1, instruction=0.
5. Fetch addr=0x2 -> addr_err=1, instruction=0. Fetch addr=0x4 with word_count=1 -> instruction=0, addr_err=0.
6. rst low midway through loading byte 3 of word 2 -> all outputs zero immediately; fetch addr=0 after release -> instruction=0; a new load then works.
